lsu_mem_ctrl: RTL and testbench
===============================

Name: lsu_mem_ctrl

Overview:
Load/store controller directly upstream of the data `ram` in the riscv_zero memory path. It accepts one pipeline memory request at a time over a valid/ready handshake and drives the RAM's doubleword-wide clk/write_enable/address/data port. It handles B/H/W/D sizes, read-modify-write for sub-doubleword stores, sign/zero extension on loads, and misalignment detection. Results return on a valid/ready response channel.

Parameters:
RD_LATENCY, 1, clock edges from a stable mem_addr to a valid mem_rdata (0 = combinational RAM read); legal range 0..7
ADDR_W, 64, byte address width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request
req_we  in  1  1 = store, 0 = load
req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = double
req_unsigned  in  1  load zero-extends when 1, sign-extends when 0; ignored for stores
req_addr  in  ADDR_W  byte address
req_wdata  in  64  store data, right-justified
resp_valid  out  1  response present
resp_ready  in  1  consumer takes the response
resp_rdata  out  64  extended load data; 0 for stores and errors
resp_err  out  1  misaligned access; no RAM access was made
mem_we  out  1  to ram.write_enable
mem_addr  out  ADDR_W  to ram.address; always 8-byte aligned (bits [2:0] = 0)
mem_wdata  out  64  to ram.data_in
mem_rdata  in  64  from ram.data_out

Behaviour:
- Reset is asynchronous and active-high:
  - State = IDLE; resp_valid = 0, resp_err = 0, resp_rdata = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - req_ready = 0 while reset is high.
  - Reset mid-operation aborts the operation. mem_we drops immediately, no partial write completes, and no response is produced.
- States: IDLE, READ, WRITE, RESP.
- req_ready = 1 only in IDLE. Acceptance occurs on a rising edge with req_valid & req_ready; the request is registered at that edge.
- Alignment: access is misaligned if addr mod (1<<req_size) != 0.
  - Misaligned requests go IDLE -> RESP at the accept edge with resp_err = 1 and resp_rdata = 0. The RAM is never touched.
- Aligned load: IDLE -> READ.
  - mem_addr = {addr[ADDR_W-1:3], 3'b000}; counter loaded with RD_LATENCY.
  - Each READ edge with counter != 0 decrements it.
  - The edge with counter == 0 captures mem_rdata and moves to RESP. READ therefore lasts RD_LATENCY+1 cycles.
  - Lane select is by addr[2:0] (little-endian; byte k = mem_rdata[8k+7:8k]).
  - The selected lane is extended to 64 bits per req_unsigned.
- Aligned doubleword store: IDLE -> WRITE. One cycle with mem_we = 1 and mem_wdata = req_wdata, then RESP.
- Aligned sub-doubleword store: IDLE -> READ (as for a load) -> WRITE -> RESP.
  - In WRITE, mem_wdata is the captured doubleword with only the addressed lane(s) replaced by the low 8/16/32 bits of req_wdata. All other bytes are preserved bit-exact.
- RESP: resp_valid = 1 and is held, with resp_rdata/resp_err stable, until resp_ready. RESP -> IDLE on the edge where resp_ready = 1.
  - A new request cannot be accepted in that same cycle, so throughput is at most one request per N+1 cycles.
- Response timing (edges after the accept edge at which resp_valid rises):
  - misaligned: 0
  - D store: 1
  - load: RD_LATENCY+1
  - sub-word store: RD_LATENCY+2
- mem_we = 1 only in WRITE. mem_addr holds its last value outside READ/WRITE. mem_wdata = 0 outside WRITE.
- Request inputs are ignored outside the accept edge. Changes on them mid-operation have no effect.

Optional Feature:
LSU_STATS_EN:
- Defined: adds three 32-bit outputs, stat_loads, stat_stores and stat_misaligned.
  - Each increments on the accept edge of the matching request class. Misaligned requests count only in stat_misaligned.
  - Each saturates at 32'hFFFF_FFFF and is cleared to 0 by reset.
- Undefined: these ports and their logic do not exist. Core behaviour is identical either way.

Test Plan:
1. Store D addr=0x20 data=0x1122334455667788, then load D addr=0x20 -> resp_rdata = 0x1122334455667788, resp_err = 0; D-store resp_valid 1 edge after accept; load resp_valid 2 edges after accept (RD_LATENCY=1).
2. With 0x20 preloaded as in 1: store B addr=0x23 data=0xAB -> RAM[0x20] = 0x11223344AB667788. Then load B signed at 0x23 -> 0xFFFFFFFFFFFFFFAB; load B unsigned -> 0x00000000000000AB.
3. Store W addr=0x2C data=0x80000000 into zeroed RAM, then load W signed at 0x2C -> 0xFFFFFFFF80000000. Load H unsigned at 0x2E -> 0x0000000000008000.
4. Load W at addr 0x22 (misaligned) -> resp_err = 1, resp_rdata = 0, resp_valid at accept edge +0, mem_we never 1. Store H at 0x21 -> resp_err = 1, RAM unchanged.
5. Hold resp_ready = 0 for 5 cycles after a load -> resp_valid, resp_rdata stable and req_ready = 0 throughout. Raise resp_ready -> IDLE next edge, req_ready = 1.
6. Assert reset during the WRITE cycle of a sub-word store to 0x40 holding 0x0 -> mem_we = 0 immediately, resp_valid = 0, RAM[0x40] = 0x0. With LSU_STATS_EN: after tests 1–4, stat_loads = 5, stat_stores = 3, stat_misaligned = 2.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller in front of the doubleword-wide data RAM: sized loads with extension,
// read-modify-write for narrow stores, misalignment errors. Optional counters: LSU_STATS_EN.
module lsu_mem_ctrl #(
  parameter int RD_LATENCY = 1,
  parameter int ADDR_W     = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [63:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [63:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [63:0]       mem_wdata,
  input  logic [63:0]       mem_rdata
`ifdef LSU_STATS_EN
  ,
  output logic [31:0]       stat_loads,
  output logic [31:0]       stat_stores,
  output logic [31:0]       stat_misaligned
`endif
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t      state, state_next;
  logic [2:0]  offs;
  logic [1:0]  size_q;
  logic        we_q;
  logic        uns_q;
  logic [63:0] wdata_q;
  logic [2:0]  cnt;
  logic [63:0] wr_data;

  logic        accept;
  logic        misaligned;
  logic [2:0]  align_mask;
  logic [5:0]  shift;
  logic [63:0] size_mask;
  logic [63:0] lane;
  logic [63:0] loaded;
  logic [63:0] merged;

  assign req_ready  = (state == IDLE) && !reset;
  assign accept     = req_valid && req_ready;
  assign resp_valid = (state == RESP);
  assign mem_we     = (state == WRITE);
  assign mem_wdata  = mem_we ? wr_data : 64'd0;

  always_comb begin
    case (req_size)
      2'b00:   align_mask = 3'b000;
      2'b01:   align_mask = 3'b001;
      2'b10:   align_mask = 3'b011;
      default: align_mask = 3'b111;
    endcase
  end
  assign misaligned = |(req_addr[2:0] & align_mask);

  // Lane extraction and byte-lane merge on the doubleword currently on mem_rdata.
  assign shift = {offs, 3'b000};
  assign lane  = mem_rdata >> shift;

  always_comb begin
    case (size_q)
      2'b00: begin
        size_mask = 64'h0000_0000_0000_00FF;
        loaded    = {{56{lane[7] & ~uns_q}}, lane[7:0]};
      end
      2'b01: begin
        size_mask = 64'h0000_0000_0000_FFFF;
        loaded    = {{48{lane[15] & ~uns_q}}, lane[15:0]};
      end
      2'b10: begin
        size_mask = 64'h0000_0000_FFFF_FFFF;
        loaded    = {{32{lane[31] & ~uns_q}}, lane[31:0]};
      end
      default: begin
        size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        loaded    = lane;
      end
    endcase
  end
  assign merged = (mem_rdata & ~(size_mask << shift)) | ((wdata_q & size_mask) << shift);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (misaligned)                       state_next = RESP;
          else if (req_we && req_size == 2'b11) state_next = WRITE;
          else                                  state_next = READ;
        end
      end
      READ:    if (cnt == 3'd0) state_next = we_q ? WRITE : RESP;
      WRITE:   state_next = RESP;
      RESP:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      offs       <= 3'd0;
      size_q     <= 2'd0;
      we_q       <= 1'b0;
      uns_q      <= 1'b0;
      wdata_q    <= 64'd0;
      cnt        <= 3'd0;
      wr_data    <= 64'd0;
      mem_addr   <= '0;
      resp_rdata <= 64'd0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          offs    <= req_addr[2:0];
          size_q  <= req_size;
          we_q    <= req_we;
          uns_q   <= req_unsigned;
          wdata_q <= req_wdata;
          cnt     <= 3'(RD_LATENCY);
          if (misaligned) begin
            resp_err   <= 1'b1;
            resp_rdata <= 64'd0;
          end else begin
            mem_addr <= {req_addr[ADDR_W-1:3], 3'b000};
            wr_data  <= req_wdata;
          end
        end
        READ: begin
          if (cnt != 3'd0) begin
            cnt <= cnt - 3'd1;
          end else if (we_q) begin
            wr_data <= merged;
          end else begin
            resp_rdata <= loaded;
            resp_err   <= 1'b0;
          end
        end
        WRITE: begin
          resp_rdata <= 64'd0;
          resp_err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef LSU_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_loads      <= 32'd0;
      stat_stores     <= 32'd0;
      stat_misaligned <= 32'd0;
    end else if (accept) begin
      if (misaligned) begin
        if (stat_misaligned != 32'hFFFF_FFFF) stat_misaligned <= stat_misaligned + 32'd1;
      end else if (req_we) begin
        if (stat_stores != 32'hFFFF_FFFF) stat_stores <= stat_stores + 32'd1;
      end else begin
        if (stat_loads != 32'hFFFF_FFFF) stat_loads <= stat_loads + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a behavioural RAM (one-cycle registered read).
module tb_lsu_mem_ctrl;
  localparam int RD_LAT = 1;
  localparam int AW     = 64;

  logic          clk, reset;
  logic          req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]    req_size;
  logic [AW-1:0] req_addr;
  logic [63:0]   req_wdata;
  logic          resp_valid, resp_ready, resp_err;
  logic [63:0]   resp_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [63:0]   mem_wdata, mem_rdata;
`ifdef LSU_STATS_EN
  logic [31:0]   stat_loads, stat_stores, stat_misaligned;
`endif

  lsu_mem_ctrl #(.RD_LATENCY(RD_LAT), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef LSU_STATS_EN
    , .stat_loads(stat_loads), .stat_stores(stat_stores), .stat_misaligned(stat_misaligned)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: 64 doublewords, registered read, synchronous write.
  logic [63:0] ram [0:63];
  logic        ram_clr;
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 64; i++) ram[i] <= 64'd0;
    end else if (mem_we === 1'b1) begin
      ram[mem_addr[8:3]] <= mem_wdata;
    end
    mem_rdata <= ram[mem_addr[8:3]];
  end

  int we_cnt = 0;
  always @(posedge clk) if (mem_we === 1'b1) we_cnt <= we_cnt + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    logic        chk_ram;
    int          ram_idx;
    logic [63:0] ram_exp;
  } vec_t;

  vec_t vecs [10];

  // Caller is #1 after a rising edge; returns #1 after the edge where resp_valid is seen.
  task automatic issue(input vec_t v, output int lat);
    int n;
    req_valid = 1'b1; req_we = v.we; req_size = v.size; req_unsigned = v.uns;
    req_addr = v.addr; req_wdata = v.wdata;
    n = 0;
    while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    // Scribble on the request inputs to show they are ignored after acceptance.
    req_valid = 1'b0; req_addr = 64'hFFFF_FFFF_FFFF_FFF8; req_wdata = 64'hDEAD_BEEF_DEAD_BEEF;
    req_size = 2'b11; req_we = 1'b0; req_unsigned = ~v.uns;
    lat = 0;
    while (!resp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic release_resp();
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, we_before;
    logic [63:0] held;

    vecs[0] = '{1'b1, 2'b11, 1'b0, 64'h20, 64'h1122334455667788, 64'h0, 1'b0, 1, 1'b1, 4, 64'h1122334455667788};
    vecs[1] = '{1'b0, 2'b11, 1'b0, 64'h20, 64'h0, 64'h1122334455667788, 1'b0, 2, 1'b0, 0, 64'h0};
    vecs[2] = '{1'b1, 2'b00, 1'b0, 64'h23, 64'h00000000000000AB, 64'h0, 1'b0, 3, 1'b1, 4, 64'h11223344AB667788};
    vecs[3] = '{1'b0, 2'b00, 1'b0, 64'h23, 64'h0, 64'hFFFFFFFFFFFFFFAB, 1'b0, 2, 1'b0, 0, 64'h0};
    vecs[4] = '{1'b0, 2'b00, 1'b1, 64'h23, 64'h0, 64'h00000000000000AB, 1'b0, 2, 1'b0, 0, 64'h0};
    vecs[5] = '{1'b1, 2'b10, 1'b0, 64'h2C, 64'h0000000080000000, 64'h0, 1'b0, 3, 1'b1, 5, 64'h8000000000000000};
    vecs[6] = '{1'b0, 2'b10, 1'b0, 64'h2C, 64'h0, 64'hFFFFFFFF80000000, 1'b0, 2, 1'b0, 0, 64'h0};
    vecs[7] = '{1'b0, 2'b01, 1'b1, 64'h2E, 64'h0, 64'h0000000000008000, 1'b0, 2, 1'b0, 0, 64'h0};
    vecs[8] = '{1'b0, 2'b10, 1'b0, 64'h22, 64'h0, 64'h0, 1'b1, 0, 1'b0, 0, 64'h0};
    vecs[9] = '{1'b1, 2'b01, 1'b0, 64'h21, 64'h0000000000001234, 64'h0, 1'b1, 0, 1'b1, 4, 64'h11223344AB667788};

    reset = 1'b1; ram_clr = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_err", 64'(resp_err), 64'd0);
    chk("rst_resp_rdata", resp_rdata, 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_mem_addr", mem_addr, 64'd0);
    chk("rst_mem_wdata", mem_wdata, 64'd0);
    reset = 1'b0; ram_clr = 1'b0;
    @(posedge clk); #1;
    chk("idle_req_ready", 64'(req_ready), 64'd1);

    for (int i = 0; i < 10; i++) begin
      we_before = we_cnt;
      issue(vecs[i], lat);
      $display("txn %0d: we=%0b size=%0d addr=%h -> rdata=%h err=%0b lat=%0d",
               i, vecs[i].we, vecs[i].size, vecs[i].addr, resp_rdata, resp_err, lat);
      chk($sformatf("v%0d_lat", i), 64'(lat), 64'(vecs[i].exp_lat));
      chk($sformatf("v%0d_rdata", i), resp_rdata, vecs[i].exp_rdata);
      chk($sformatf("v%0d_err", i), 64'(resp_err), 64'(vecs[i].exp_err));
      release_resp();
      chk($sformatf("v%0d_ready_after", i), 64'(req_ready), 64'd1);
      if (vecs[i].exp_err) chk($sformatf("v%0d_no_we", i), 64'(we_cnt), 64'(we_before));
      if (vecs[i].chk_ram) chk($sformatf("v%0d_ram", i), ram[vecs[i].ram_idx], vecs[i].ram_exp);
    end

`ifdef LSU_STATS_EN
    chk("stat_loads", 64'(stat_loads), 64'd5);
    chk("stat_stores", 64'(stat_stores), 64'd3);
    chk("stat_misaligned", 64'(stat_misaligned), 64'd2);
`endif

    // Response held under back-pressure.
    issue('{1'b0, 2'b11, 1'b0, 64'h20, 64'h0, 64'h0, 1'b0, 2, 1'b0, 0, 64'h0}, lat);
    held = resp_rdata;
    chk("bp_rdata", held, 64'h11223344AB667788);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      $display("txn bp cycle %0d: resp_valid=%0b rdata=%h req_ready=%0b", c, resp_valid, resp_rdata, req_ready);
      chk($sformatf("bp%0d_valid", c), 64'(resp_valid), 64'd1);
      chk($sformatf("bp%0d_rdata", c), resp_rdata, held);
      chk($sformatf("bp%0d_ready", c), 64'(req_ready), 64'd0);
    end
    release_resp();
    chk("bp_idle_ready", 64'(req_ready), 64'd1);
    chk("bp_idle_valid", 64'(resp_valid), 64'd0);

    // Reset during the WRITE cycle of a byte store to 0x41 (RAM[0x40] holds 0).
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 64'h41; req_wdata = 64'hFF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t6_in_write", 64'(mem_we), 64'd1);
    reset = 1'b1;
    #1;
    chk("t6_we_drop", 64'(mem_we), 64'd0);
    chk("t6_wdata_zero", mem_wdata, 64'd0);
    chk("t6_no_resp", 64'(resp_valid), 64'd0);
    chk("t6_ready_low", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    chk("t6_ram_intact", ram[8], 64'd0);
    @(posedge clk); #1;
    $display("txn reset-abort: mem_we=%0b resp_valid=%0b req_ready=%0b ram40=%h", mem_we, resp_valid, req_ready, ram[8]);
    chk("t6_ready_after", 64'(req_ready), 64'd1);
    chk("t6_valid_after", 64'(resp_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
